// File: rtl/ymux_pkg.sv
// Shared definitions for the two-requester round-robin arbiter:
// the FSM state encoding and the default payload width.
package ymux_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/yMux.sv
// WIDTH-bit 2-to-1 payload mux assembled from yMux1 slices.
module yMux
    import ymux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        yMux1 u_slice (
            .a   (a[i]),
            .b   (b[i]),
            .sel (sel),
            .z   (y[i])
        );
    end

endmodule

// File: rtl/yMux1.sv
// One-bit 2-to-1 mux slice; sel=0 passes a, sel=1 passes b.
module yMux1 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic z
);

    assign z = sel ? b : a;

endmodule

// File: rtl/ymux_arb.sv
// Two-requester round-robin arbiter feeding a single registered output word.
// A new word is granted whenever the output register is empty or being drained.
module ymux_arb
    import ymux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic             sel
);

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_src_q, out_src_d;
    logic [WIDTH-1:0] mux_data;
    logic             load_en;
    logic             grant;
    logic             gnt_id;

    yMux #(.WIDTH(WIDTH)) u_mux (
        .a   (req0_data),
        .b   (req1_data),
        .sel (sel),
        .y   (mux_data)
    );

    // Grant is gated by rst_n so no requester sees ready while reset is held.
    always_comb begin
        load_en    = (state_q == EMPTY) || out_ready;
        gnt_id     = (req0_valid && req1_valid) ? prio_q : req1_valid;
        grant      = rst_n && load_en && (req0_valid || req1_valid);
        sel        = grant ? gnt_id : prio_q;
        req0_ready = grant && !gnt_id;
        req1_ready = grant && gnt_id;

        state_d    = state_q;
        prio_d     = prio_q;
        out_data_d = out_data_q;
        out_src_d  = out_src_q;

        if (grant) begin
            state_d    = FULL;
            prio_d     = ~gnt_id;
            out_data_d = mux_data;
            out_src_d  = gnt_id;
        end else if (state_q == FULL && out_ready) begin
            state_d    = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            prio_q     <= 1'b0;
            out_data_q <= '0;
            out_src_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule
